// File: rtl/log_div_pkg.sv
// Shared types and constants for the sequential Mitchell log divider.
package log_div_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_LOG_N = 3;
  localparam int DEF_K     = 5;
  localparam int DEF_LOG_K = 3;

  localparam int LOG_W = DEF_LOG_N + DEF_K + 1;
  localparam int RES_W = 2 * DEF_N;

  // Largest positive Q(N.N) magnitude, reported on divide-by-zero
  localparam logic [RES_W-1:0] DBZ_MAG = {1'b0, {(RES_W-1){1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_SUB   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/log_div_norm.sv
// One operand's normaliser: left-shifts until the leading one sits at bit N-2,
// counting the shifts, and extracts the K-bit log fraction (rounded when LOG_DIV_ROUND_EN).
module log_div_norm
  import log_div_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LOG_N = DEF_LOG_N,
  parameter int K     = DEF_K
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [N-2:0]     i_mag,
  output logic             o_norm,
  output logic [LOG_N-1:0] o_lz,
  output logic [K-1:0]     o_frac
);

  logic [N-2:0]     r_mag;
  logic [LOG_N-1:0] r_lz;
  logic [N-1:0]     w_ext;
  logic [K-1:0]     w_trunc;
  logic             w_unused;

  // Shift register and leading-zero counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag <= {(N-1){1'b0}};
      r_lz  <= {LOG_N{1'b0}};
    end else if (i_load) begin
      r_mag <= i_mag;
      r_lz  <= {LOG_N{1'b0}};
    end else if (i_step && !r_mag[N-2]) begin
      r_mag <= {r_mag[N-3:0], 1'b0};
      r_lz  <= r_lz + LOG_N'(1);
    end
  end

  // A zero guard bit below the register keeps the round-bit index valid when K == N-2
  assign w_ext    = {r_mag, 1'b0};
  assign w_trunc  = w_ext[N-2:N-1-K];
  assign o_norm   = r_mag[N-2];
  assign o_lz     = r_lz;
  assign w_unused = ^w_ext;

`ifdef LOG_DIV_ROUND_EN
  logic [K:0] w_sum;
  assign w_sum  = {1'b0, w_trunc} + {{K{1'b0}}, w_ext[N-2-K]};
  assign o_frac = w_sum[K] ? {K{1'b1}} : w_sum[K-1:0];
`else
  assign o_frac = w_trunc;
`endif

endmodule

// File: rtl/log_div_k_seq.sv
// Sequential Mitchell logarithmic divider, one's-complement Q(N.N) quotient.
// Optional fraction rounding selected by the LOG_DIV_ROUND_EN macro.
module log_div_k_seq
  import log_div_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LOG_N = DEF_LOG_N,
  parameter int K     = DEF_K,
  parameter int LOG_K = DEF_LOG_K
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z,
  output logic           dbz
);

  localparam int LW = LOG_N + K + 1;
  localparam int RW = 2 * N;
  localparam int CW = LOG_N + 1;
  localparam logic [RW-1:0]    W_SAT  = {1'b0, {(RW-1){1'b1}}};
  localparam logic [LOG_N-1:0] W_KMAX = LOG_N'(N - 2);

  if ((K > N - 2) || ((1 << LOG_K) < K) || ((1 << LOG_N) < N)) begin : g_bad_cfg
    $error("log_div_k_seq: inconsistent N/LOG_N/K/LOG_K");
  end

  state_e           r_state;
  logic             r_sign, r_left, r_out_valid, r_dbz;
  logic [RW-1:0]    r_res, r_z;
  logic [LOG_N-1:0] r_cnt;

  logic [N-2:0]     w_ma, w_mb;
  logic             w_sign, w_accept, w_step, w_norm_a, w_norm_b;
  logic [LOG_N-1:0] w_lz_a, w_lz_b;
  logic [K-1:0]     w_fa, w_fb;
  logic [LW-1:0]    w_la, w_lb, w_d;
  logic [CW-1:0]    w_c, w_c_abs;
  logic [RW-1:0]    w_r0;
  logic             w_unused;

  assign w_ma     = a[N-1] ? ~a[N-2:0] : a[N-2:0];
  assign w_mb     = b[N-1] ? ~b[N-2:0] : b[N-2:0];
  assign w_sign   = a[N-1] ^ b[N-1];
  assign w_accept = in_valid & (r_state == ST_IDLE);
  assign w_step   = (r_state == ST_NORM);

  log_div_norm #(.N(N), .LOG_N(LOG_N), .K(K)) u_norm_a (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .i_mag(w_ma),
    .o_norm(w_norm_a), .o_lz(w_lz_a), .o_frac(w_fa)
  );

  log_div_norm #(.N(N), .LOG_N(LOG_N), .K(K)) u_norm_b (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .i_mag(w_mb),
    .o_norm(w_norm_b), .o_lz(w_lz_b), .o_frac(w_fb)
  );

  // Log difference: integer part c = floor(D / 2^K), fraction f = D[K-1:0]
  assign w_la     = {1'b0, W_KMAX - w_lz_a, w_fa};
  assign w_lb     = {1'b0, W_KMAX - w_lz_b, w_fb};
  assign w_d      = w_la - w_lb;
  assign w_c      = w_d[LW-1:K];
  assign w_c_abs  = w_c[CW-1] ? (CW'(0) - w_c) : w_c;
  assign w_r0     = RW'({1'b1, w_d[K-1:0]}) << (N - K);
  assign w_unused = w_c_abs[CW-1];

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_left      <= 1'b0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_res       <= {RW{1'b0}};
      r_z         <= {RW{1'b0}};
      r_cnt       <= {LOG_N{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sign <= w_sign;
            if (w_mb == {(N-1){1'b0}}) begin
              r_state     <= ST_DONE;
              r_dbz       <= 1'b1;
              r_z         <= w_sign ? ~W_SAT : W_SAT;
              r_out_valid <= 1'b1;
            end else if (w_ma == {(N-1){1'b0}}) begin
              r_state     <= ST_DONE;
              r_dbz       <= 1'b0;
              r_z         <= {RW{w_sign}};
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_NORM;
              r_dbz   <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          if (w_norm_a && w_norm_b) begin
            r_state <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_res   <= w_r0;
          r_cnt   <= w_c_abs[LOG_N-1:0];
          r_left  <= ~w_c[CW-1];
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cnt == {LOG_N{1'b0}}) begin
            r_state     <= ST_DONE;
            r_z         <= r_sign ? ~r_res : r_res;
            r_out_valid <= 1'b1;
          end else begin
            r_res <= r_left ? (r_res << 1) : (r_res >> 1);
            r_cnt <= r_cnt - LOG_N'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_log_div_k_seq.sv
// Directed self-checking bench for log_div_k_seq (N=8, K=5); expectations
// follow the LOG_DIV_ROUND_EN macro where rounding changes the result.
module tb_log_div_k_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, dbz;
  logic [7:0]  a, b;
  logic [15:0] z;
  int          n_cmp = 0;
  int          n_err = 0;

  log_div_k_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .z(z), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency = edges after the accepting edge until out_valid is seen (0: valid right after accept)
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] ez, input logic ed, input int elat, input int hold);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_in_ready"}, in_ready, 32'd1);
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_valid"}, out_valid, 32'd1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_dbz"}, dbz, ed);
    chk({tag, "_busy"}, in_ready, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_z"}, z, ez);
      chk({tag, "_hold_valid"}, out_valid, 32'd1);
      chk({tag, "_hold_busy"}, in_ready, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [15:0] e_round;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_dbz", dbz, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 32'd1);

    run_op("p12_3",   8'h0C, 8'h03, 16'h0400, 1'b0, 10, 0);
    run_op("n12_3",   8'hF3, 8'h03, 16'hFBFF, 1'b0, 10, 0);
    run_op("p12_n3",  8'h0C, 8'hFC, 16'hFBFF, 1'b0, 10, 0);
    run_op("p3_12",   8'h03, 8'h0C, 16'h0040, 1'b0, 10, 0);
    run_op("p100_1",  8'h64, 8'h01, 16'h6400, 1'b0, 15, 0);
    run_op("p7_3",    8'h07, 8'h03, 16'h0280, 1'b0, 9, 0);
    run_op("dbz_pos", 8'h05, 8'h00, 16'h7FFF, 1'b1, 0, 0);
    run_op("dbz_neg", 8'h85, 8'hFF, 16'h7FFF, 1'b1, 0, 0);
    run_op("dbz_mix", 8'h05, 8'hFF, 16'h8000, 1'b1, 0, 0);
    run_op("zero_a",  8'h00, 8'h05, 16'h0000, 1'b0, 0, 0);
    run_op("nzero_a", 8'hFF, 8'h05, 16'hFFFF, 1'b0, 0, 0);
`ifdef LOG_DIV_ROUND_EN
    e_round = 16'h6600;
`else
    e_round = 16'h6400;
`endif
    run_op("p101_1",  8'h65, 8'h01, e_round, 1'b0, 15, 0);
    run_op("hold",    8'h0C, 8'h03, 16'h0400, 1'b0, 10, 5);

    // Abort an operation while it is still normalising
    a = 8'h64; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_valid", out_valid, 32'd0);
    chk("abort_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 32'd0);
    run_op("after_abort", 8'h07, 8'h03, 16'h0280, 1'b0, 9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
